// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
//   ID/EX pipeline register for the pipelined MIPS datapath. Registers the
//   decoder control word, operands and register addresses into EX. It also
//   detects load-use hazards and inserts a bubble on them. A taken
//   branch/jump resolved in EX squashes the ID instruction. Two saturating
//   counters count the bubbles and the flushes.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-low reset
//   id_valid_i            IF/ID holds a real instruction
//   id_<ctrl>_i           decoder control bits, aluop[3:0], branchtype[1:0]
//   id_pc4/rs_data/rt_data/imm_i   32-bit PC+4, operands, sign-extended imm
//   id_rs/rt/rd_i         5-bit register addresses
//   ex_flush_i            branch/jump taken in EX this cycle
//   ex_*_o                registered copies of the id_* inputs
//   stall_o               load-use hazard this cycle (combinational)
//   pc_write_o            PC write enable      (= ~stall_o)
//   ifid_write_o          IF/ID write enable   (= ~stall_o)
//   bubble_cnt_o          saturating count of stall bubbles
//   flush_cnt_o           saturating count of flushes
// -----------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic             id_regwrite_i,
    input  logic             id_alusrc_i,
    input  logic             id_regdst_i,
    input  logic             id_branch_i,
    input  logic             id_memtoreg_i,
    input  logic             id_jump_i,
    input  logic             id_memread_i,
    input  logic             id_memwrite_i,
    input  logic             id_cjal_i,
    input  logic [3:0]       id_aluop_i,
    input  logic [1:0]       id_branchtype_i,
    input  logic [31:0]      id_pc4_i,
    input  logic [31:0]      id_rs_data_i,
    input  logic [31:0]      id_rt_data_i,
    input  logic [31:0]      id_imm_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       id_rd_i,
    input  logic             ex_flush_i,
    output logic             ex_valid_o,
    output logic             ex_regwrite_o,
    output logic             ex_alusrc_o,
    output logic             ex_regdst_o,
    output logic             ex_branch_o,
    output logic             ex_memtoreg_o,
    output logic             ex_jump_o,
    output logic             ex_memread_o,
    output logic             ex_memwrite_o,
    output logic             ex_cjal_o,
    output logic [3:0]       ex_aluop_o,
    output logic [1:0]       ex_branchtype_o,
    output logic [31:0]      ex_pc4_o,
    output logic [31:0]      ex_rs_data_o,
    output logic [31:0]      ex_rt_data_o,
    output logic [31:0]      ex_imm_o,
    output logic [4:0]       ex_rs_o,
    output logic [4:0]       ex_rt_o,
    output logic [4:0]       ex_rd_o,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        alusrc;
        logic        regdst;
        logic        branch;
        logic        memtoreg;
        logic        jump;
        logic        memread;
        logic        memwrite;
        logic        cjal;
        logic [3:0]  aluop;
        logic [1:0]  branchtype;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_t  ex_q;
    ex_t  ex_d;
    logic uses_rt;
    logic hazard;
    logic load_id;

    // rt is a source unless the immediate replaces it. Stores and branches
    // still read it even though alusrc may be set.
    assign uses_rt = ~id_alusrc_i | id_memwrite_i | id_branch_i;

    assign hazard = ex_q.valid & ex_q.memread & (ex_q.rt != 5'd0) & id_valid_i &
                    ((ex_q.rt == id_rs_i) | (uses_rt & (ex_q.rt == id_rt_i)));

    // A flush squashes the dependent instruction, so it never needs to wait.
    assign stall_o      = hazard & ~ex_flush_i;
    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;

    // Only a real, unsquashed, unstalled instruction is loaded into EX.
    // Every other case loads an all-zero bubble.
    assign load_id = id_valid_i & ~ex_flush_i & ~stall_o;

    // NOTE: ex_d gets its default before any branch. If a branch leaves it
    // unassigned, always_comb would need a latch to hold the old value.
    always_comb begin
        ex_d = '0;
        if (load_id) begin
            ex_d.valid      = 1'b1;
            ex_d.regwrite   = id_regwrite_i;
            ex_d.alusrc     = id_alusrc_i;
            ex_d.regdst     = id_regdst_i;
            ex_d.branch     = id_branch_i;
            ex_d.memtoreg   = id_memtoreg_i;
            ex_d.jump       = id_jump_i;
            ex_d.memread    = id_memread_i;
            ex_d.memwrite   = id_memwrite_i;
            ex_d.cjal       = id_cjal_i;
            ex_d.aluop      = id_aluop_i;
            ex_d.branchtype = id_branchtype_i;
            ex_d.pc4        = id_pc4_i;
            ex_d.rs_data    = id_rs_data_i;
            ex_d.rt_data    = id_rt_data_i;
            ex_d.imm        = id_imm_i;
            ex_d.rs         = id_rs_i;
            ex_d.rt         = id_rt_i;
            ex_d.rd         = id_rd_i;
        end
    end

    // NOTE: state uses non-blocking assignments. Every flop then samples
    // values from before the edge, whatever order the blocks evaluate in.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_q         <= '0;
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            ex_q <= ex_d;
            if (ex_flush_i) begin
                if (flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end else if (stall_o) begin
                if (bubble_cnt_o != CNT_MAX) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
            end
        end
    end

    assign ex_valid_o      = ex_q.valid;
    assign ex_regwrite_o   = ex_q.regwrite;
    assign ex_alusrc_o     = ex_q.alusrc;
    assign ex_regdst_o     = ex_q.regdst;
    assign ex_branch_o     = ex_q.branch;
    assign ex_memtoreg_o   = ex_q.memtoreg;
    assign ex_jump_o       = ex_q.jump;
    assign ex_memread_o    = ex_q.memread;
    assign ex_memwrite_o   = ex_q.memwrite;
    assign ex_cjal_o       = ex_q.cjal;
    assign ex_aluop_o      = ex_q.aluop;
    assign ex_branchtype_o = ex_q.branchtype;
    assign ex_pc4_o        = ex_q.pc4;
    assign ex_rs_data_o    = ex_q.rs_data;
    assign ex_rt_data_o    = ex_q.rt_data;
    assign ex_imm_o        = ex_q.imm;
    assign ex_rs_o         = ex_q.rs;
    assign ex_rt_o         = ex_q.rt;
    assign ex_rd_o         = ex_q.rd;

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline stage for the pipelined MIPS datapath. It sits directly downstream of the instruction decoder and register file, and registers the decoder control word, operands and register addresses into the EX stage. It detects load-use hazards, holding PC and IF/ID and inserting a bubble; it also squashes the ID instruction on a taken branch or jump resolved in EX. Two saturating counters record bubbles and flushes for lab performance reporting.

## Interface
- CNT_W, 16, width of bubble/flush performance counters
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- id_valid_i  in  1  IF/ID holds a real instruction
- id_regwrite_i, id_alusrc_i, id_regdst_i, id_branch_i, id_memtoreg_i, id_jump_i, id_memread_i, id_memwrite_i, id_cjal_i  in  1 each  decoder control bits
- id_aluop_i  in  4  decoder ALU op code (0..13)
- id_branchtype_i  in  2  branch condition select (0 eq, 1 gt, 2 gez/gnz, 3 ne)
- id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i  in  32 each  PC+4, register reads, sign-extended immediate
- id_rs_i, id_rt_i, id_rd_i  in  5 each  register addresses
- ex_flush_i  in  1  branch/jump taken, resolved in EX this cycle
- ex_* outputs  out  same widths as id_* inputs  registered copies (ex_valid_o, ex_regwrite_o ... ex_rd_o)
- stall_o  out  1  load-use hazard this cycle
- pc_write_o  out  1  PC write enable (= ~stall_o)
- ifid_write_o  out  1  IF/ID write enable (= ~stall_o)
- bubble_cnt_o  out  CNT_W  bubbles inserted by stall
- flush_cnt_o  out  CNT_W  flushes applied

## Operation
- uses_rt = ~id_alusrc_i | id_memwrite_i | id_branch_i.
- Hazard (combinational): ex_valid_o & ex_memread_o & (ex_rt_o != 0) & id_valid_i & ((ex_rt_o == id_rs_i) | (uses_rt & ex_rt_o == id_rt_i)).
- stall_o = hazard & ~ex_flush_i; the flush squashes the ID instruction, so no stall is needed.
- Per-edge update priority:
  1. rst_i low: every ex_* output goes to 0, both counters go to 0.
  2. ex_flush_i: load a bubble; flush_cnt increments.
  3. stall_o: load a bubble; bubble_cnt increments.
  4. Otherwise: load id_* into ex_*.
- Bubble: ex_valid_o = 0 and all control outputs (regwrite, memread, memwrite, branch, jump, cjal, aluop, branchtype, alusrc, regdst, memtoreg) = 0. Data/address fields are don't-care; the implementation drives them to 0.
- When id_valid_i = 0 on a normal load, control outputs are forced to 0 (same as a bubble) and no counter increments.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A stall is never more than one cycle: after the bubble, ex_memread_o = 0.

## Timing
- Latency 1 cycle ID to EX. stall_o, pc_write_o and ifid_write_o are combinational from current ex_* and id_* values, valid the same cycle.
- Reset: synchronous only. rst_i asserted mid-stall clears the stall on that edge; stall_o is 0 the cycle after reset deasserts, because ex_valid_o = 0.
- Flush and hazard together: bubble, flush_cnt +1, bubble_cnt unchanged, stall_o = 0.
- Counters update on the same edge as the bubble is loaded.
- No combinational path from ex_flush_i to any ex_* register output.

## Test plan
- Reset: hold rst_i = 0 for 2 cycles with random id_* -> all ex_* = 0, counters = 0, stall_o = 0.
- Pass-through: ADDI (aluop 1, alusrc 1, regwrite 1, rt = 8, imm = 0x5) -> next cycle ex_aluop_o = 1, ex_imm_o = 0x5, ex_rt_o = 8, ex_valid_o = 1, stall_o = 0.
- Load-use stall:
  - Setup: LW into rt = 9 in EX, ID is R-type with rs = 9.
  - Hazard cycle: stall_o = 1, pc_write_o = 0.
  - Next edge: bubble in EX, bubble_cnt = 1.
  - Following cycle: stall_o = 0 and the R-type enters EX.
- No false hazards:
  - LW rt = 0 with ID rs = 0 -> stall_o = 0.
  - LW rt = 9 with ADDI rt = 9 in ID (alusrc 1, rt not a source) -> stall_o = 0.
  - SW rt = 9 in ID -> stall_o = 1.
- Flush with simultaneous hazard: ex_flush_i = 1 while a load-use hazard is present -> stall_o = 0, EX bubble, flush_cnt = 1, bubble_cnt = 0.
- Saturation: CNT_W = 2, apply 5 consecutive flushes -> flush_cnt_o stays at 3.
